// File: rtl/route_allocator.sv
// route_allocator: per-router output-port allocator for the mesh NoC.
// Each input presents a route-reserve request naming one output port; every
// free output picks a winner round-robin, pulses grant to it for one cycle
// and then holds the reservation (and the crossbar select) until the owning
// input reports its tail flit popped via relieve.
module route_allocator #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 req_valid,
  input  logic [N*REQUEST_WIDTH-1:0]   req_port,
  input  logic [N-1:0]                 relieve,
  output logic [N-1:0]                 grant,
  output logic [N-1:0]                 in_routed,
  output logic [N-1:0]                 out_busy,
  output logic [N*REQUEST_WIDTH-1:0]   sel
);

  typedef logic [REQUEST_WIDTH-1:0] port_t;

  // Registered allocation state
  logic [N-1:0] busy;
  port_t        owner  [N];
  port_t        rr_ptr [N];

  // Combinational arbitration results
  logic [N-1:0] elig [N];       // elig[o][i]: input i may win output o this cycle
  logic [N-1:0] win_valid;
  port_t        win_idx  [N];
  port_t        win_next [N];
  logic [N-1:0] grant_next;
  logic [N-1:0] release_in;
  logic [N-1:0] release_out;

  // Eligibility matrix; a port index >= N matches no output, so such requests never win
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path can leave it unassigned and infer a latch.
    for (int o = 0; o < N; o++) begin
      elig[o] = '0;
      for (int i = 0; i < N; i++) begin
        elig[o][i] = req_valid[i]
                   & (int'(req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH]) == o)
                   & ~in_routed[i] & ~grant[i] & ~busy[o];
      end
    end
  end

  // Round-robin pick per output: first eligible input scanning from rr_ptr upward, mod N
  always_comb begin
    win_valid = '0;
    for (int o = 0; o < N; o++) begin
      win_idx[o]  = '0;
      win_next[o] = '0;
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < N; i++) begin
          if (!win_valid[o] && (i == (int'(rr_ptr[o]) + k) % N) && elig[o][i]) begin
            win_valid[o] = 1'b1;
            win_idx[o]   = port_t'(i);
            win_next[o]  = port_t'((i + 1) % N);
          end
        end
      end
    end
  end

  // Fold per-output winners into per-input grants, and map relieves onto the outputs they free
  always_comb begin
    grant_next  = '0;
    release_out = '0;
    release_in  = relieve & in_routed;  // a relieve from an unrouted input is ignored
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        if (win_valid[o] && int'(win_idx[o]) == i) grant_next[i] = 1'b1;
        if (busy[o] && int'(owner[o]) == i && release_in[i]) release_out[o] = 1'b1;
      end
    end
  end

  // State update: reset drops every reservation; otherwise apply releases and new grants
  always_ff @(posedge clk) begin
    // NOTE: owner and rr_ptr are a handful of flops, not a RAM, so they are
    // reset with everything else; rr_ptr must restart at input 0.
    if (rst) begin
      grant     <= '0;
      in_routed <= '0;
      busy      <= '0;
      for (int o = 0; o < N; o++) begin
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
      end
    end else begin
      // NOTE: all sequential state uses non-blocking assignment so every
      // flop sees the values from before this edge, regardless of order.
      grant     <= grant_next;
      // A granted input was unrouted, so it cannot also be releasing this edge
      in_routed <= (in_routed & ~release_in) | grant_next;
      for (int o = 0; o < N; o++) begin
        // Release needs busy=1 and a grant needs busy=0, so the two never collide
        if (release_out[o]) begin
          busy[o] <= 1'b0;
        end else if (win_valid[o]) begin
          busy[o]   <= 1'b1;
          owner[o]  <= win_idx[o];
          rr_ptr[o] <= win_next[o];
        end
      end
    end
  end

  // Outputs: busy flags and crossbar selects; sel keeps the last owner after release
  always_comb begin
    out_busy = busy;
    sel      = '0;
    for (int o = 0; o < N; o++) begin
      sel[o*REQUEST_WIDTH +: REQUEST_WIDTH] = owner[o];
    end
  end

endmodule
